mdu_sequencer: RTL and testbench

MDU_SEQUENCER -- requirements
Module: mdu_sequencer

---
 rtl/mdu_sequencer.sv | 175 +++++++++++++++++
 tb/tb_mdu_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// Multiply/divide sequencer for the execute stage: a single-cycle 32x32 multiply
// and a 32-iteration radix-2 restoring divide, with pipeline stall/ready handshake.
module mdu_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        startE,
    input  logic        mulOrdivE,
    input  logic        mdIsSignE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    input  logic        flushE,
    input  logic        advE,
    output logic        stallMdE,
    output logic        readyE,
    output logic [31:0] hiE,
    output logic [31:0] loE
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            sign_q, sign_d;
    logic [W-1:0]    rem_q, rem_d;
    logic [W-1:0]    quo_q, quo_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;
    logic            ready_q, ready_d;

    logic [W-1:0]    amag_in;
    logic [W-1:0]    bmag;
    logic [W:0]      trial;
    logic [W:0]      diff;
    logic            fits;
    logic [W-1:0]    rem_nx;
    logic [W-1:0]    quo_nx;
    logic [2*W-1:0]  a_ext;
    logic [2*W-1:0]  b_ext;
    logic [2*W-1:0]  prod;
    logic            q_neg;
    logic            r_neg;
    logic [W-1:0]    quo_fix;
    logic [W-1:0]    rem_fix;

    // Datapath: operand magnitudes, one restoring step, product and sign fix
    always_comb begin
        amag_in = (mdIsSignE && srcaE[W-1]) ? ((~srcaE) + W'(1)) : srcaE;
        bmag    = (sign_q && b_q[W-1]) ? ((~b_q) + W'(1)) : b_q;
        trial   = {rem_q, quo_q[W-1]};
        diff    = trial - {1'b0, bmag};
        fits    = ~diff[W];
        rem_nx  = fits ? diff[W-1:0] : trial[W-1:0];
        quo_nx  = {quo_q[W-2:0], fits};

        // Extending both operands to 64 bits makes the truncated product exact
        a_ext   = sign_q ? {{W{a_q[W-1]}}, a_q} : {{W{1'b0}}, a_q};
        b_ext   = sign_q ? {{W{b_q[W-1]}}, b_q} : {{W{1'b0}}, b_q};
        prod    = a_ext * b_ext;

        q_neg   = sign_q & (a_q[W-1] ^ b_q[W-1]);
        r_neg   = sign_q & a_q[W-1];
        quo_fix = q_neg ? ((~quo_nx) + W'(1)) : quo_nx;
        rem_fix = r_neg ? ((~rem_nx) + W'(1)) : rem_nx;
    end

    // Next-state and output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        sign_d   = sign_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        ready_d  = 1'b0;
        stallMdE = 1'b0;

        case (state_q)
            IDLE: begin
                stallMdE = startE & ~flushE;
                if (startE && !flushE) begin
                    a_d     = srcaE;
                    b_d     = srcbE;
                    sign_d  = mdIsSignE;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = amag_in;
                    state_d = mulOrdivE ? DIV : MUL;
                end
            end
            MUL: begin
                stallMdE = 1'b1;
                if (flushE) begin
                    state_d = IDLE;
                end else begin
                    hi_d    = prod[2*W-1:W];
                    lo_d    = prod[W-1:0];
                    ready_d = 1'b1;
                    state_d = DONE;
                end
            end
            DIV: begin
                stallMdE = 1'b1;
                if (flushE) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    cnt_d = CW'(cnt_q + CW'(1));
                    if (cnt_q == CW'(W - 1)) begin
                        hi_d    = rem_fix;
                        lo_d    = quo_fix;
                        cnt_d   = '0;
                        ready_d = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (flushE || advE) begin
                    state_d = IDLE;
                end else begin
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            ready_q <= ready_d;
        end
    end

    assign readyE = ready_q;
    assign hiE    = hi_q;
    assign loE    = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: arithmetic reference model with per-cycle compare,
// plus directed operations with hand-computed results and latencies.
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        startE = 1'b0;
    logic        mulOrdivE = 1'b0;
    logic        mdIsSignE = 1'b0;
    logic [31:0] srcaE = '0;
    logic [31:0] srcbE = '0;
    logic        flushE = 1'b0;
    logic        advE = 1'b0;
    logic        stallMdE;
    logic        readyE;
    logic [31:0] hiE;
    logic [31:0] loE;

    int checks = 0;
    int errors = 0;

    mdu_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .startE    (startE),
        .mulOrdivE (mulOrdivE),
        .mdIsSignE (mdIsSignE),
        .srcaE     (srcaE),
        .srcbE     (srcbE),
        .flushE    (flushE),
        .advE      (advE),
        .stallMdE  (stallMdE),
        .readyE    (readyE),
        .hiE       (hiE),
        .loE       (loE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result {hi,lo} straight from the arithmetic definition
    function automatic logic [63:0] ref_md(input logic div, input logic sgn,
                                           input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, m;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!div) begin
            if (sgn) r = 64'(sa * sb);
            else     r = {32'd0, a} * {32'd0, b};
        end else if (!sgn) begin
            if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
            else            r = {a % b, a / b};
        end else begin
            if (b == 32'd0) begin
                r = {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
            end else begin
                q = sa / sb;
                m = sa % sb;
                r = {m[31:0], q[31:0]};
            end
        end
        return r;
    endfunction

    // Transaction-level model: busy countdown, then a held result until advance
    bit          m_busy  = 1'b0;
    bit          m_ready = 1'b0;
    int          m_left  = 0;
    logic [63:0] m_pend  = '0;
    logic [63:0] m_res   = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_ready <= 1'b0;
            m_left  <= 0;
            m_res   <= '0;
        end else if (m_ready) begin
            if (flushE || advE) m_ready <= 1'b0;
        end else if (m_busy) begin
            if (flushE) begin
                m_busy <= 1'b0;
            end else if (m_left == 1) begin
                m_busy  <= 1'b0;
                m_ready <= 1'b1;
                m_res   <= m_pend;
            end else begin
                m_left <= m_left - 1;
            end
        end else if (startE && !flushE) begin
            m_busy <= 1'b1;
            m_left <= mulOrdivE ? 32 : 1;
            m_pend <= ref_md(mulOrdivE, mdIsSignE, srcaE, srcbE);
        end
    end

    always @(negedge clk) begin
        logic exp_stall;
        exp_stall = m_busy ? 1'b1 : (m_ready ? 1'b0 : (startE & ~flushE));
        chk("cyc_stall", 64'(stallMdE), 64'(exp_stall));
        chk("cyc_ready", 64'(readyE), 64'(m_ready));
        chk("cyc_hilo", {hiE, loE}, m_res);
    end

    // Issue one operation from IDLE; returns cycles-to-ready and stalled cycles
    task automatic run_op(input logic div, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, output int lat, output int stl);
        startE    = 1'b1;
        mulOrdivE = div;
        mdIsSignE = sgn;
        srcaE     = a;
        srcbE     = b;
        lat = 0;
        stl = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stallMdE) stl++;
            @(posedge clk);
            #1;
            lat++;
            if (i == 0) begin
                srcaE = $urandom;
                srcbE = $urandom;
            end
            if (readyE) break;
        end
        startE = 1'b0;
        if (!readyE) chk("ready_timeout", 64'(readyE), 64'd1);
    endtask

    task automatic advance();
        advE = 1'b1;
        @(posedge clk);
        #1;
        advE = 1'b0;
    endtask

    task automatic op_check(input string name, input logic div, input logic sgn,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ehi, input logic [31:0] elo);
        int lat, stl;
        run_op(div, sgn, a, b, lat, stl);
        chk({name, "_lat"}, 64'(lat), div ? 64'd33 : 64'd2);
        chk({name, "_stall"}, 64'(stl), div ? 64'd33 : 64'd2);
        chk({name, "_hilo"}, {hiE, loE}, {ehi, elo});
    endtask

    initial begin
        int seen;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_hilo", {hiE, loE}, 64'd0);
        chk("rst_ready", 64'(readyE), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        op_check("mulu_ff_x2", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
        advance();
        op_check("div_m7_2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        advance();
        op_check("divu_100_7", 1'b1, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14);
        advance();
        op_check("div_7_m2", 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
        advance();
        op_check("div_m5_0", 1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'd1);
        advance();
        op_check("div_min_m1", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        advance();
        op_check("divu_by0", 1'b1, 1'b0, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
        advance();

        // Flush a divide at T+10
        startE = 1'b1; mulOrdivE = 1'b1; mdIsSignE = 1'b0; srcaE = 32'd100; srcbE = 32'd7;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
        end
        flushE = 1'b1;
        startE = 1'b0;
        @(posedge clk);
        #1;
        flushE = 1'b0;
        chk("flush_ready", 64'(readyE), 64'd0);
        chk("flush_stall", 64'(stallMdE), 64'd0);
        chk("flush_hilo", {hiE, loE}, {32'h1234_5678, 32'hFFFF_FFFF});
        seen = 0;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            if (readyE) seen++;
        end
        chk("flush_noready", 64'(seen), 64'd0);
        @(posedge clk);
        #1;

        // Hold in DONE, then back-to-back multiply
        op_check("mul_3_m5", 1'b0, 1'b1, 32'd3, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("hold_ready", 64'(readyE), 64'd1);
            chk("hold_hilo", {hiE, loE}, {32'hFFFF_FFFF, 32'hFFFF_FFF1});
        end
        advance();
        op_check("mul_min_m1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        advance();

        // Asynchronous reset between edges at T+5 of a divide
        startE = 1'b1; mulOrdivE = 1'b1; mdIsSignE = 1'b1; srcaE = 32'd1000; srcbE = 32'd3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
        end
        startE = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_hilo", {hiE, loE}, 64'd0);
        chk("arst_ready", 64'(readyE), 64'd0);
        chk("arst_stall", 64'(stallMdE), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (readyE) seen++;
        end
        chk("arst_noready", 64'(seen), 64'd0);
        @(posedge clk);
        #1;
        op_check("mulu_6_7", 1'b0, 1'b0, 32'd6, 32'd7, 32'd0, 32'd42);
        advance();

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
